// File: rtl/button_conditioner_if.sv
// rtl/button_conditioner_if.sv - button bundle between board pins and game logic
//
// Purpose: groups the raw button lines and the conditioned per-channel
// outputs of button_conditioner into one bundle.
//   master : board/stimulus side; drives btn_raw and observes the outputs
//   slave  : button_conditioner side; samples btn_raw and drives the outputs
// Signals (all CHANNELS wide, active-high):
//   btn_raw      raw button levels, asynchronous to clk
//   btn_level    debounced level
//   btn_press    one-cycle pulse on an accepted 0->1
//   btn_release  one-cycle pulse on an accepted 1->0
//   btn_repeat   press pulse followed by auto-repeat pulses (masked channels)
interface button_conditioner_if #(
    parameter int CHANNELS = 3
);
    logic [CHANNELS-1:0] btn_raw;
    logic [CHANNELS-1:0] btn_level;
    logic [CHANNELS-1:0] btn_press;
    logic [CHANNELS-1:0] btn_release;
    logic [CHANNELS-1:0] btn_repeat;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_repeat
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_repeat
    );
endinterface

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - per-channel button synchroniser, debouncer and auto-repeat
//
// Purpose: conditions each raw push-button line independently: two-flop
// synchroniser, stable-count debouncer, press/release edge pulses and an
// auto-repeat pulse train for channels selected by REPEAT_MASK.
// Ports:
//   clk     system clock, rising edge
//   reset   asynchronous active-low reset; all state and outputs clear at once
//   btn_if  slave side of button_conditioner_if (btn_raw in; btn_level,
//           btn_press, btn_release, btn_repeat out, all registered)
module button_conditioner #(
    parameter int                  CHANNELS        = 3,
    parameter int                  DEBOUNCE_CYCLES = 500000,
    parameter int                  REPEAT_DELAY    = 25000000,
    parameter int                  REPEAT_PERIOD   = 5000000,
    parameter logic [CHANNELS-1:0] REPEAT_MASK     = CHANNELS'(3'b011)
) (
    input  logic                  clk,
    input  logic                  reset,
    button_conditioner_if.slave   btn_if
);

    localparam int CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RMAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RCNT_W = $clog2(RMAX + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RCNT_W-1:0] DELAY_LAST = RCNT_W'(REPEAT_DELAY - 1);
    localparam logic [RCNT_W-1:0] PER_LAST   = RCNT_W'(REPEAT_PERIOD - 1);

    logic [CHANNELS-1:0] sync1_q, sync1_d;
    logic [CHANNELS-1:0] sync2_q, sync2_d;
    logic [CHANNELS-1:0] level_q, level_d;
    logic [CHANNELS-1:0] press_q, press_d;
    logic [CHANNELS-1:0] release_q, release_d;
    logic [CHANNELS-1:0] repeat_q, repeat_d;
    logic [CHANNELS-1:0] first_q, first_d;
    logic [CNT_W-1:0]    cnt_q  [CHANNELS];
    logic [CNT_W-1:0]    cnt_d  [CHANNELS];
    logic [RCNT_W-1:0]   rcnt_q [CHANNELS];
    logic [RCNT_W-1:0]   rcnt_d [CHANNELS];

    always_comb begin
        sync1_d   = btn_if.btn_raw;
        sync2_d   = sync1_q;
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        repeat_d  = '0;
        first_d   = first_q;
        cnt_d     = cnt_q;
        rcnt_d    = rcnt_q;

        for (int c = 0; c < CHANNELS; c++) begin
            // Debounce: a change is accepted only after DEBOUNCE_CYCLES
            // consecutive samples disagree with the current level.
            if (sync2_q[c] == level_q[c]) begin
                cnt_d[c] = '0;
            end else if (cnt_q[c] == CNT_LAST) begin
                level_d[c]   = sync2_q[c];
                cnt_d[c]     = '0;
                press_d[c]   = sync2_q[c];
                release_d[c] = ~sync2_q[c];
            end else begin
                cnt_d[c] = cnt_q[c] + CNT_W'(1);
            end

            // Auto-repeat: the press itself is the first repeat pulse; then
            // REPEAT_DELAY to the second and REPEAT_PERIOD between the rest.
            // A release in this cycle (release_d) aborts the sequence so no
            // repeat pulse can coincide with the falling level.
            if (press_d[c]) begin
                repeat_d[c] = 1'b1;
                rcnt_d[c]   = '0;
                first_d[c]  = 1'b1;
            end else if (REPEAT_MASK[c] && level_q[c] && !release_d[c]) begin
                if ((first_q[c] && rcnt_q[c] == DELAY_LAST) ||
                    (!first_q[c] && rcnt_q[c] == PER_LAST)) begin
                    repeat_d[c] = 1'b1;
                    rcnt_d[c]   = '0;
                    first_d[c]  = 1'b0;
                end else begin
                    rcnt_d[c] = rcnt_q[c] + RCNT_W'(1);
                end
            end else begin
                rcnt_d[c] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            repeat_q  <= '0;
            first_q   <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                cnt_q[c]  <= '0;
                rcnt_q[c] <= '0;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
            first_q   <= first_d;
            cnt_q     <= cnt_d;
            rcnt_q    <= rcnt_d;
        end
    end

    assign btn_if.btn_level   = level_q;
    assign btn_if.btn_press   = press_q;
    assign btn_if.btn_release = release_q;
    assign btn_if.btn_repeat  = repeat_q;

endmodule
